// File: rtl/pc_target_gen.sv
// Registered next-PC / link-address generator behind a 1-entry valid/ready output stage.
// Define PC_TARGET_MISALIGN_EN to register a misaligned-redirect flag with each result.
module pc_target_gen #(
  parameter int XLEN       = 32,
  parameter int IMM_SHIFT  = 0,
  parameter int INST_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_redirect,
  output logic             out_misalign,
  output logic [CNT_W-1:0] out_redir_cnt
);

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'b00,
    MODE_BRANCH = 2'b01,
    MODE_JAL    = 2'b10,
    MODE_JALR   = 2'b11
  } mode_e;

  logic [XLEN-1:0]  off;
  logic [XLEN-1:0]  seq_sum;
  logic [XLEN-1:0]  pc_sum;
  logic [XLEN-1:0]  rs1_sum;
  logic [XLEN-1:0]  target_d;
  logic             redirect_d;
  logic             accept;
  logic             handoff;

  logic             out_valid_q;
  logic [XLEN-1:0]  target_q;
  logic [XLEN-1:0]  link_q;
  logic             redirect_q;
  logic [CNT_W-1:0] redir_cnt_q;

  assign off     = in_imm << IMM_SHIFT;
  assign seq_sum = in_pc + XLEN'(INST_BYTES);
  assign pc_sum  = in_pc + off;
  assign rs1_sum = in_rs1 + off;

  // in_ready deliberately ignores flush so upstream handshakes stay simple
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = out_valid_q && out_ready;

  always_comb begin
    target_d   = seq_sum;
    redirect_d = 1'b0;
    case (mode_e'(in_mode))
      MODE_SEQ: begin
        target_d   = seq_sum;
        redirect_d = 1'b0;
      end
      MODE_BRANCH: begin
        target_d   = in_taken ? pc_sum : seq_sum;
        redirect_d = in_taken;
      end
      MODE_JAL: begin
        target_d   = pc_sum;
        redirect_d = 1'b1;
      end
      MODE_JALR: begin
        target_d   = {rs1_sum[XLEN-1:1], 1'b0};
        redirect_d = 1'b1;
      end
      default: begin
        target_d   = seq_sum;
        redirect_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
      redirect_q  <= 1'b0;
      redir_cnt_q <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        target_q   <= target_d;
        link_q     <= seq_sum;
        redirect_q <= redirect_d;
      end

      // a handoff in the same cycle as flush is still a completed handoff
      if (handoff && redirect_q && (redir_cnt_q != {CNT_W{1'b1}})) begin
        redir_cnt_q <= redir_cnt_q + 1'b1;
      end
    end
  end

`ifdef PC_TARGET_MISALIGN_EN
  logic misalign_d;
  logic misalign_q;

  // target is passed through unchanged; the trap is raised downstream
  always_comb begin
    if (INST_BYTES == 2) begin
      misalign_d = redirect_d && target_d[0];
    end else begin
      misalign_d = redirect_d && (target_d[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= misalign_d;
    end
  end

  assign out_misalign = misalign_q;
`else
  assign out_misalign = 1'b0;
`endif

  assign out_valid     = out_valid_q;
  assign out_target    = target_q;
  assign out_link      = link_q;
  assign out_redirect  = redirect_q;
  assign out_redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pc_target_gen.sv
// Scoreboard bench for pc_target_gen; honours PC_TARGET_MISALIGN_EN when defined.
module tb_pc_target_gen;
  localparam int XLEN       = 32;
  localparam int IMM_SHIFT  = 0;
  localparam int INST_BYTES = 4;
  localparam int CNT_W      = 4;

  localparam logic [1:0] M_SEQ = 2'b00, M_BR = 2'b01, M_JAL = 2'b10, M_JALR = 2'b11;

  logic             clock = 1'b0;
  logic             reset, flush, in_valid, in_ready, in_taken;
  logic [1:0]       in_mode;
  logic [XLEN-1:0]  in_pc, in_rs1, in_imm;
  logic             out_valid, out_ready, out_redirect, out_misalign;
  logic [XLEN-1:0]  out_target, out_link;
  logic [CNT_W-1:0] out_redir_cnt;

  typedef struct packed {
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            redirect;
    logic            misalign;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] m_cnt = '0;
  logic             mon_en = 1'b0;
  int               checks = 0;
  int               errors = 0;

`ifdef PC_TARGET_MISALIGN_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  pc_target_gen #(
    .XLEN(XLEN), .IMM_SHIFT(IMM_SHIFT), .INST_BYTES(INST_BYTES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_imm(in_imm), .in_taken(in_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_target(out_target), .out_link(out_link),
    .out_redirect(out_redirect), .out_misalign(out_misalign),
    .out_redir_cnt(out_redir_cnt)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [1:0] m, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                                 input logic tk);
    exp_t e;
    logic [XLEN-1:0] o;
    o          = imm << IMM_SHIFT;
    e.link     = pc + XLEN'(INST_BYTES);
    e.target   = e.link;
    e.redirect = 1'b0;
    case (m)
      M_BR:   if (tk) begin e.target = pc + o; e.redirect = 1'b1; end
      M_JAL:  begin e.target = pc + o; e.redirect = 1'b1; end
      M_JALR: begin e.target = (rs1 + o) & ~XLEN'(1); e.redirect = 1'b1; end
      default: ;
    endcase
    e.misalign = MIS_EN && e.redirect && ((e.target % XLEN'(INST_BYTES)) != '0);
    return e;
  endfunction

  // reference model of the output stage, advanced on the same edge as the DUT
  always @(posedge clock) begin
    if (reset) begin
      sb.delete();
      m_cnt <= '0;
    end else if (sb.size() != 0 && out_ready) begin
      if (sb[0].redirect && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
      void'(sb.pop_front());
      if (!flush && in_valid) sb.push_back(model(in_mode, in_pc, in_rs1, in_imm, in_taken));
    end else if (sb.size() == 0) begin
      if (!flush && in_valid) sb.push_back(model(in_mode, in_pc, in_rs1, in_imm, in_taken));
    end else if (flush) begin
      sb.delete();
    end
  end

  // scoreboard monitor: compares the held result against the queue head
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL mon_valid: got %b expected %b", out_valid, sb.size() != 0);
      end
      checks++;
      if (in_ready !== (sb.size() == 0 || out_ready)) begin
        errors++;
        $display("FAIL mon_in_ready: got %b expected %b", in_ready, (sb.size() == 0 || out_ready));
      end
      checks++;
      if (out_redir_cnt !== m_cnt) begin
        errors++;
        $display("FAIL mon_redir_cnt: got %0d expected %0d", out_redir_cnt, m_cnt);
      end
      if (sb.size() != 0 && out_valid === 1'b1) begin
        checks++;
        if ({out_target, out_link, out_redirect, out_misalign} !== sb[0]) begin
          errors++;
          $display("FAIL mon_data: got t=%h l=%h r=%b m=%b expected t=%h l=%h r=%b m=%b",
                   out_target, out_link, out_redirect, out_misalign,
                   sb[0].target, sb[0].link, sb[0].redirect, sb[0].misalign);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                       input logic tk);
    in_mode  = m;
    in_pc    = pc;
    in_rs1   = rs1;
    in_imm   = imm;
    in_taken = tk;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    cyc(); cyc();
    @(negedge clock);
    checks++;
    if ({out_valid, out_target, out_link, out_redirect, out_misalign, out_redir_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b t=%h l=%h r=%b m=%b c=%0d expected all zero",
               out_valid, out_target, out_link, out_redirect, out_misalign, out_redir_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_seq();
    drive(M_SEQ, 32'h100, 32'h0, 32'h0, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_target !== 32'h104 || out_link !== 32'h104 || out_redirect !== 1'b0) begin
      errors++;
      $display("FAIL seq: got v=%b t=%h l=%h r=%b expected v=1 t=104 l=104 r=0",
               out_valid, out_target, out_link, out_redirect);
    end
    cyc();
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      drive(M_BR, 32'h200, 32'h0, 32'hFFFF_FFF8, t[0]);
      cyc();
      in_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (out_target !== (t[0] ? 32'h1F8 : 32'h204) || out_redirect !== t[0]) begin
        errors++;
        $display("FAIL branch_taken%0d: got t=%h r=%b expected t=%h r=%b",
                 t, out_target, out_redirect, (t[0] ? 32'h1F8 : 32'h204), t[0]);
      end
      cyc();
    end
  endtask

  task automatic test_jal_jalr();
    drive(M_JALR, 32'h40, 32'h1003, 32'h4, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_target !== 32'h1006 || out_link !== 32'h44 || out_redirect !== 1'b1) begin
      errors++;
      $display("FAIL jalr: got t=%h l=%h r=%b expected t=1006 l=44 r=1", out_target, out_link, out_redirect);
    end
    cyc();
    drive(M_JAL, 32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_target !== 32'h4 || out_link !== 32'h0 || out_redirect !== 1'b1) begin
      errors++;
      $display("FAIL jal_wrap: got t=%h l=%h r=%b expected t=4 l=0 r=1", out_target, out_link, out_redirect);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(M_SEQ, 32'h300, 32'h0, 32'h0, 1'b0);
    cyc();
    drive(M_JAL, 32'h400, 32'h0, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_target !== 32'h304 || out_link !== 32'h304) begin
        errors++;
        $display("FAIL stall_hold%0d: got rdy=%b v=%b t=%h l=%h expected rdy=0 v=1 t=304 l=304",
                 i, in_ready, out_valid, out_target, out_link);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? M_SEQ : M_JAL, 32'h500 + XLEN'(i * 16), 32'h0, 32'h20, 1'b0);
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bubble%0d: got out_valid=%b expected 1", i, out_valid);
      end
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] cnt0;
    out_ready = 1'b0;
    drive(M_JAL, 32'h600, 32'h0, 32'h20, 1'b0);
    cyc();
    cnt0 = m_cnt;
    drive(M_SEQ, 32'h700, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || out_redir_cnt !== cnt0) begin
        errors++;
        $display("FAIL flush_hold%0d: got v=%b cnt=%0d expected v=0 cnt=%0d", i, out_valid, out_redir_cnt, cnt0);
      end
      cyc();
    end
    drive(M_JAL, 32'h800, 32'h0, 32'h40, 1'b0);
    cyc();
    cnt0 = m_cnt;
    drive(M_SEQ, 32'h900, 32'h0, 32'h0, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || out_redir_cnt !== cnt0 + 1'b1) begin
      errors++;
      $display("FAIL flush_handoff: got v=%b cnt=%0d expected v=0 cnt=%0d", out_valid, out_redir_cnt, cnt0 + 1'b1);
    end
    cyc();
  endtask

  task automatic test_misalign();
    drive(M_JAL, 32'h100, 32'h0, 32'h6, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_target !== 32'h106 || out_misalign !== MIS_EN) begin
      errors++;
      $display("FAIL misalign: got t=%h m=%b expected t=106 m=%b", out_target, out_misalign, MIS_EN);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(M_JAL, 32'hA00, 32'h0, 32'h8, 1'b0);
    cyc();
    in_valid = 1'b0; reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_redir_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=0", out_valid, in_ready, out_redir_cnt);
    end
    cyc();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      drive(M_JAL, XLEN'(i * 4), 32'h0, 32'h40, 1'b0);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    @(negedge clock);
    checks++;
    if (out_redir_cnt !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL redir_saturate: got %0d expected %0d", out_redir_cnt, {CNT_W{1'b1}});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = M_SEQ; in_pc = '0; in_rs1 = '0; in_imm = '0; in_taken = 1'b0;
    test_reset();
    test_seq();
    test_branch();
    test_jal_jalr();
    test_back_to_back();
    test_flush();
    test_misalign();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
